// File: rtl/cavlc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cavlc_pkg : shared CAVLC coeff_token types and limits              |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cavlc_pkg;

  typedef enum logic [2:0] {
    TBL_VLC0 = 3'd0,
    TBL_VLC1 = 3'd1,
    TBL_VLC2 = 3'd2,
    TBL_FLC  = 3'd3,
    TBL_CDC  = 3'd4
  } table_sel_e;

  typedef enum logic [1:0] {
    BLK_LUMA      = 2'd0,
    BLK_CHROMA_AC = 2'd1,
    BLK_CHROMA_DC = 2'd2,
    BLK_RSVD      = 2'd3
  } blk_type_e;

  localparam logic [4:0] MAX_TC     = 5'd16;
  localparam logic [4:0] MAX_TC_CDC = 5'd4;

endpackage
`default_nettype wire

// File: rtl/cavlc_nc_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cavlc_nc_sel : neighbour counts -> nC and coeff_token table select |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cavlc_nc_sel
  import cavlc_pkg::*;
(
  input  logic [4:0]        na_i,
  input  logic [4:0]        nb_i,
  input  logic              na_avail_i,
  input  logic              nb_avail_i,
  input  logic [1:0]        blk_type_i,
  output logic signed [5:0] nc_o,
  output logic [2:0]        tbl_o
);

  logic [4:0] avg_w;

  // Rounded-up mean of both neighbours; the 6-bit sum cannot overflow (max 33).
  assign avg_w = 5'((6'(na_i) + 6'(nb_i) + 6'd1) >> 1);

  always_comb begin
    nc_o = 6'sd0;
    if (blk_type_i == BLK_CHROMA_DC) begin
      nc_o = -6'sd1;
    end else if (na_avail_i && nb_avail_i) begin
      nc_o = signed'({1'b0, avg_w});
    end else if (na_avail_i) begin
      nc_o = signed'({1'b0, na_i});
    end else if (nb_avail_i) begin
      nc_o = signed'({1'b0, nb_i});
    end
  end

  always_comb begin
    tbl_o = TBL_FLC;
    if (nc_o < 6'sd0) begin
      tbl_o = TBL_CDC;
    end else if (nc_o < 6'sd2) begin
      tbl_o = TBL_VLC0;
    end else if (nc_o < 6'sd4) begin
      tbl_o = TBL_VLC1;
    end else if (nc_o < 6'sd8) begin
      tbl_o = TBL_VLC2;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cavlc_coeff_token_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cavlc_coeff_token_ctrl : per-block coeff_token lookup sequencer     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cavlc_coeff_token_ctrl
  import cavlc_pkg::*;
#(
  parameter int LUT_LATENCY = 1,
  parameter int CODE_W      = 16,
  parameter int LEN_W       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        tc_i,
  input  logic [1:0]        t1_i,
  input  logic [1:0]        blk_type_i,
  input  logic [4:0]        na_i,
  input  logic [4:0]        nb_i,
  input  logic              na_avail_i,
  input  logic              nb_avail_i,
  output logic [2:0]        lut_sel_o,
  output logic [4:0]        lut_tc_o,
  output logic [1:0]        lut_t1_o,
  input  logic [CODE_W-1:0] lut_code_i,
  input  logic [LEN_W-1:0]  lut_len_i,
  output logic              code_valid_o,
  input  logic              code_ready_i,
  output logic [CODE_W-1:0] code_bits_o,
  output logic [LEN_W-1:0]  code_len_o,
  output logic              err_o
);

  localparam int CNT_W = (LUT_LATENCY < 2) ? 1 : $clog2(LUT_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_OUT    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic [2:0]         lut_sel_q, lut_sel_d;
  logic [4:0]         lut_tc_q, lut_tc_d;
  logic [1:0]         lut_t1_q, lut_t1_d;
  logic               code_valid_q, code_valid_d;
  logic [CODE_W-1:0]  code_bits_q, code_bits_d;
  logic [LEN_W-1:0]   code_len_q, code_len_d;
  logic               err_q, err_d;

  logic signed [5:0]  nc_w;
  logic [2:0]         tbl_w;
  logic               illegal_w;

  cavlc_nc_sel u_nc_sel (
    .na_i       (na_i),
    .nb_i       (nb_i),
    .na_avail_i (na_avail_i),
    .nb_avail_i (nb_avail_i),
    .blk_type_i (blk_type_i),
    .nc_o       (nc_w),
    .tbl_o      (tbl_w)
  );

  // A negative nC marks a chroma DC block, whose table only covers up to 4 coefficients.
  assign illegal_w = (tc_i > MAX_TC) || ({3'b000, t1_i} > tc_i) ||
                     ((nc_w < 6'sd0) && (tc_i > MAX_TC_CDC)) ||
                     (blk_type_i == BLK_RSVD);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    lut_sel_d    = lut_sel_q;
    lut_tc_d     = lut_tc_q;
    lut_t1_d     = lut_t1_q;
    code_valid_d = code_valid_q;
    code_bits_d  = code_bits_q;
    code_len_d   = code_len_q;
    err_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          if (illegal_w) begin
            err_d = 1'b1;
          end else begin
            state_d     = ST_LOOKUP;
            cnt_d       = CNT_W'(LUT_LATENCY);
            req_ready_d = 1'b0;
            lut_sel_d   = tbl_w;
            lut_tc_d    = tc_i;
            lut_t1_d    = t1_i;
          end
        end
      end
      ST_LOOKUP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = ST_OUT;
          code_valid_d = 1'b1;
          code_bits_d  = lut_code_i;
          code_len_d   = lut_len_i;
          lut_sel_d    = 3'd0;
          lut_tc_d     = 5'd0;
          lut_t1_d     = 2'd0;
        end
      end
      ST_OUT: begin
        if (code_ready_i) begin
          state_d      = ST_IDLE;
          code_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b0;
      lut_sel_q    <= 3'd0;
      lut_tc_q     <= 5'd0;
      lut_t1_q     <= 2'd0;
      code_valid_q <= 1'b0;
      code_bits_q  <= '0;
      code_len_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      lut_sel_q    <= lut_sel_d;
      lut_tc_q     <= lut_tc_d;
      lut_t1_q     <= lut_t1_d;
      code_valid_q <= code_valid_d;
      code_bits_q  <= code_bits_d;
      code_len_q   <= code_len_d;
      err_q        <= err_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign lut_sel_o    = lut_sel_q;
  assign lut_tc_o     = lut_tc_q;
  assign lut_t1_o     = lut_t1_q;
  assign code_valid_o = code_valid_q;
  assign code_bits_o  = code_bits_q;
  assign code_len_o   = code_len_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_coeff_token_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cavlc_coeff_token_ctrl : directed + random bench with LUT model |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cavlc_coeff_token_ctrl;

  localparam int LAT = 2;  // edges from the accepting edge to code_valid (LUT_LATENCY+1)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  tc_i = '0, na_i = '0, nb_i = '0;
  logic [1:0]  t1_i = '0, blk_type_i = '0;
  logic        na_avail_i = 1'b0, nb_avail_i = 1'b0;
  logic [2:0]  lut_sel_o;
  logic [4:0]  lut_tc_o;
  logic [1:0]  lut_t1_o;
  logic [15:0] lut_code_i = '0;
  logic [4:0]  lut_len_i = '0;
  logic        code_valid_o;
  logic        code_ready_i = 1'b1;
  logic [15:0] code_bits_o;
  logic [4:0]  code_len_o;
  logic        err_o;

  int n_cmp = 0;
  int n_fail = 0;
  int hs_count = 0;

  cavlc_coeff_token_ctrl #(.LUT_LATENCY(1), .CODE_W(16), .LEN_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .tc_i(tc_i), .t1_i(t1_i), .blk_type_i(blk_type_i), .na_i(na_i), .nb_i(nb_i),
    .na_avail_i(na_avail_i), .nb_avail_i(nb_avail_i), .lut_sel_o(lut_sel_o),
    .lut_tc_o(lut_tc_o), .lut_t1_o(lut_t1_o), .lut_code_i(lut_code_i),
    .lut_len_i(lut_len_i), .code_valid_o(code_valid_o), .code_ready_i(code_ready_i),
    .code_bits_o(code_bits_o), .code_len_o(code_len_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // FLC entries follow the 6-bit (tc-1, t1) layout; other tables use an arbitrary pattern.
  function automatic logic [15:0] lut_code_fn(input int sel, input int tc, input int t1);
    if (sel == 3) return (tc == 0) ? 16'd3 : 16'(((tc - 1) << 2) | t1);
    return 16'(sel * 1000 + tc * 37 + t1 * 5 + 1);
  endfunction

  function automatic logic [4:0] lut_len_fn(input int sel, input int tc, input int t1);
    if (sel == 3) return 5'd6;
    return 5'((sel * 3 + tc + t1) % 16 + 1);
  endfunction

  always @(posedge clk) begin
    lut_code_i <= lut_code_fn(int'(lut_sel_o), int'(lut_tc_o), int'(lut_t1_o));
    lut_len_i  <= lut_len_fn(int'(lut_sel_o), int'(lut_tc_o), int'(lut_t1_o));
  end

  always @(posedge clk) begin
    if (rst_n && code_valid_o && code_ready_i) hs_count <= hs_count + 1;
  end

  function automatic bit ref_illegal(input int tc, input int t1, input int bt);
    return (tc > 16) || (t1 > tc) || (bt == 3) || (bt == 2 && tc > 4);
  endfunction

  function automatic int ref_sel(input int na, input int nb, input int aa, input int ab, input int bt);
    int nc;
    if (bt == 2) nc = -1;
    else if (aa != 0 && ab != 0) nc = (na + nb + 1) / 2;
    else if (aa != 0) nc = na;
    else if (ab != 0) nc = nb;
    else nc = 0;
    if (nc < 0) return 4;
    if (nc <= 1) return 0;
    if (nc <= 3) return 1;
    if (nc <= 7) return 2;
    return 3;
  endfunction

  // Presents one request from just after a posedge and records what the DUT does with it.
  task automatic do_req(input int tc, t1, bt, na, nb, aa, ab, max_wait,
                        output int err0, errl, rdy0, vs, lat, bits, len, sel, ltc, lt1);
    tc_i = 5'(tc); t1_i = 2'(t1); blk_type_i = 2'(bt);
    na_i = 5'(na); nb_i = 5'(nb); na_avail_i = 1'(aa); nb_avail_i = 1'(ab);
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    err0 = int'(err_o); rdy0 = int'(req_ready_o);
    sel = int'(lut_sel_o); ltc = int'(lut_tc_o); lt1 = int'(lut_t1_o);
    errl = 0; vs = 0; lat = 0; bits = 0; len = 0;
    for (int i = 1; i <= max_wait; i++) begin
      @(posedge clk); #1;
      if (err_o) errl = 1;
      if (code_valid_o) begin
        vs = 1; lat = i; bits = int'(code_bits_o); len = int'(code_len_o);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready_o, code_valid_o, err_o, lut_sel_o, lut_tc_o, lut_t1_o, code_bits_o, code_len_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b sel=%0d bits=%h len=%0d, required all 0",
               req_ready_o, code_valid_o, err_o, lut_sel_o, code_bits_o, code_len_o);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready_o);
    end
  endtask

  task automatic test_flc();
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    do_req(3, 1, 0, 9, 8, 1, 1, 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (sel !== 3 || ltc !== 3 || lt1 !== 1) begin
      n_fail++; $display("FAIL flc_lut_drive: sel=%0d tc=%0d t1=%0d required 3/3/1", sel, ltc, lt1);
    end
    n_cmp++;
    if (vs !== 1 || lat !== LAT || bits !== 'h9 || len !== 6 || e0 !== 0) begin
      n_fail++;
      $display("FAIL flc_code: valid=%0d lat=%0d bits=%h len=%0d err=%0d required 1/%0d/0009/6/0",
               vs, lat, bits, len, e0, LAT);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (code_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flc_handshake: valid=%b ready=%b required 0/1", code_valid_o, req_ready_o);
    end
  endtask

  task automatic test_nc_sel();
    int na[7] = '{3, 0, 4, 1, 16, 7, 0};
    int nb[7] = '{0, 0, 3, 0, 16, 8, 5};
    int aa[7] = '{1, 0, 1, 1, 1, 1, 0};
    int ab[7] = '{0, 0, 1, 1, 1, 1, 1};
    int es[7] = '{1, 0, 2, 0, 3, 3, 2};
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    for (int i = 0; i < 7; i++) begin
      do_req(5, 2, 0, na[i], nb[i], aa[i], ab[i], 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
      n_cmp++;
      if (sel !== es[i] || vs !== 1 || lat !== LAT ||
          bits !== int'(lut_code_fn(es[i], 5, 2)) || len !== int'(lut_len_fn(es[i], 5, 2))) begin
        n_fail++;
        $display("FAIL nc_sel[%0d]: sel=%0d valid=%0d lat=%0d bits=%h len=%0d required sel=%0d bits=%h len=%0d",
                 i, sel, vs, lat, bits, len, es[i], lut_code_fn(es[i], 5, 2), lut_len_fn(es[i], 5, 2));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_chroma_dc();
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    do_req(4, 3, 2, 16, 16, 1, 1, 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (sel !== 4 || vs !== 1 || bits !== int'(lut_code_fn(4, 4, 3)) || e0 !== 0) begin
      n_fail++; $display("FAIL cdc_tc4: sel=%0d valid=%0d bits=%h err=%0d required 4/1/%h/0",
                         sel, vs, bits, e0, lut_code_fn(4, 4, 3));
    end
    @(posedge clk); #1;
    do_req(5, 0, 2, 0, 0, 0, 0, 4, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (e0 !== 1 || el !== 0 || vs !== 0 || r0 !== 1) begin
      n_fail++; $display("FAIL cdc_tc5_err: err=%0d err_later=%0d valid=%0d ready=%0d required 1/0/0/1",
                         e0, el, vs, r0);
    end
  endtask

  task automatic test_illegal();
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    do_req(2, 3, 0, 0, 0, 0, 0, 4, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (e0 !== 1 || el !== 0 || vs !== 0 || r0 !== 1) begin
      n_fail++; $display("FAIL t1_gt_tc: err=%0d err_later=%0d valid=%0d ready=%0d required 1/0/0/1",
                         e0, el, vs, r0);
    end
    do_req(3, 0, 3, 0, 0, 0, 0, 4, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (e0 !== 1 || vs !== 0) begin
      n_fail++; $display("FAIL blk_rsvd: err=%0d valid=%0d required 1/0", e0, vs);
    end
    do_req(17, 0, 0, 0, 0, 0, 0, 4, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (e0 !== 1 || vs !== 0) begin
      n_fail++; $display("FAIL tc_gt16: err=%0d valid=%0d required 1/0", e0, vs);
    end
    do_req(0, 0, 1, 0, 0, 0, 0, 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    n_cmp++;
    if (e0 !== 0 || vs !== 1 || sel !== 0 || bits !== int'(lut_code_fn(0, 0, 0))) begin
      n_fail++; $display("FAIL tc0_legal: err=%0d valid=%0d sel=%0d bits=%h required 0/1/0/%h",
                         e0, vs, sel, bits, lut_code_fn(0, 0, 0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    int hs0, bad;
    hs0 = hs_count;
    bad = 0;
    code_ready_i = 1'b0;
    do_req(6, 1, 0, 2, 2, 1, 1, 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
    for (int i = 0; i < 10; i++) begin
      req_valid_i = 1'b1; tc_i = 5'($urandom_range(0, 16)); t1_i = 2'b00;
      @(posedge clk); #1;
      if (code_valid_o !== 1'b1 || req_ready_o !== 1'b0 ||
          int'(code_bits_o) !== bits || int'(code_len_o) !== len) bad++;
    end
    n_cmp++;
    if (vs !== 1 || bad !== 0 || bits !== int'(lut_code_fn(1, 6, 1))) begin
      n_fail++; $display("FAIL stall_hold: valid=%0d unstable_cycles=%0d bits=%h required 1/0/%h",
                         vs, bad, bits, lut_code_fn(1, 6, 1));
    end
    req_valid_i = 1'b0;
    code_ready_i = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (hs_count - hs0 !== 1 || code_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: handshakes=%0d valid=%b ready=%b required 1/0/1",
                         hs_count - hs0, code_valid_o, req_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    int hs0, vseen;
    hs0 = hs_count;
    vseen = 0;
    tc_i = 5'd4; t1_i = 2'd1; blk_type_i = 2'd0; na_avail_i = 1'b0; nb_avail_i = 1'b0;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    if (code_valid_o) vseen = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got %b required 1", req_ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (code_valid_o) vseen = 1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (vseen !== 0 || hs_count !== hs0) begin
      n_fail++; $display("FAIL reset_mid_drop: valid_seen=%0d handshakes=%0d required 0/0",
                         vseen, hs_count - hs0);
    end
  endtask

  task automatic test_random();
    int e0, el, r0, vs, lat, bits, len, sel, ltc, lt1;
    int tc, t1, bt, na, nb, aa, ab, es;
    bit ill;
    for (int it = 0; it < 60; it++) begin
      tc = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      t1 = $urandom_range(0, 3);
      bt = ($urandom_range(0, 5) == 0) ? 3 : $urandom_range(0, 2);
      if (bt == 2 && $urandom_range(0, 1) == 1) tc = $urandom_range(0, 4);
      na = $urandom_range(0, 16); nb = $urandom_range(0, 16);
      aa = $urandom_range(0, 1);  ab = $urandom_range(0, 1);
      ill = ref_illegal(tc, t1, bt);
      es = ref_sel(na, nb, aa, ab, bt);
      do_req(tc, t1, bt, na, nb, aa, ab, ill ? 4 : 6, e0, el, r0, vs, lat, bits, len, sel, ltc, lt1);
      n_cmp++;
      if (ill) begin
        if (e0 !== 1 || el !== 0 || vs !== 0 || r0 !== 1) begin
          n_fail++; $display("FAIL rand_illegal[%0d] tc=%0d t1=%0d bt=%0d: err=%0d valid=%0d ready=%0d required 1/0/1",
                             it, tc, t1, bt, e0, vs, r0);
        end
      end else begin
        if (e0 !== 0 || sel !== es || ltc !== tc || lt1 !== t1 || vs !== 1 || lat !== LAT ||
            bits !== int'(lut_code_fn(es, tc, t1)) || len !== int'(lut_len_fn(es, tc, t1))) begin
          n_fail++;
          $display("FAIL rand_legal[%0d] tc=%0d t1=%0d bt=%0d: err=%0d sel=%0d valid=%0d lat=%0d bits=%h len=%0d required 0/%0d/1/%0d/%h/%0d",
                   it, tc, t1, bt, e0, sel, vs, lat, bits, len, es, LAT,
                   lut_code_fn(es, tc, t1), lut_len_fn(es, tc, t1));
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_flc();
    test_nc_sel();
    test_chroma_dc();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
